// File: rtl/pixel_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_streamer_pkg
//  Brief    : Shared state encoding, frame geometry and drain depth for the
//             pixel streamer and its raster counter.
//  Revision : 1.0
// ============================================================================
package pixel_streamer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_STREAM = 2'd1;
    localparam state_t ST_FLUSH  = 2'd2;

    localparam int DEFAULT_WIDTH  = 400;
    localparam int DEFAULT_HEIGHT = 300;

    // The Gaussian stage holds four line buffers plus four horizontal taps.
    localparam int DRAIN_ROWS         = 4;
    localparam int DRAIN_TAPS         = 4;
    localparam int FILTER_DRAIN_DEPTH = DRAIN_ROWS * DEFAULT_WIDTH + DRAIN_TAPS;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int min1_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_streamer_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module   : raster_counter
//  Brief    : Column/row/linear-address tracker for a raster scan, with
//             end-of-row and end-of-frame flags.
//  Revision : 1.0
// ============================================================================
module raster_counter
    import pixel_streamer_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int ADDR_W = 17,
    localparam int COL_W = min1_clog2(WIDTH),
    localparam int ROW_W = min1_clog2(HEIGHT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [COL_W-1:0]  o_col,
    output logic [ROW_W-1:0]  o_row,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_col,
    output logic              o_last_pixel
);

    localparam int               c_col_last_i = WIDTH - 1;
    localparam int               c_row_last_i = HEIGHT - 1;
    localparam logic [COL_W-1:0] c_col_last   = c_col_last_i[COL_W-1:0];
    localparam logic [ROW_W-1:0] c_row_last   = c_row_last_i[ROW_W-1:0];

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              w_last_col;
    logic              w_last_pixel;

    assign w_last_col   = (r_col == c_col_last);
    assign w_last_pixel = w_last_col && (r_row == c_row_last);

    // Everything wraps to zero after the last pixel, so the address never
    // runs past WIDTH*HEIGHT-1 even when that fills the address space.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (i_advance) begin
            r_col  <= w_last_col ? '0 : r_col + 1'b1;
            if (w_last_col) begin
                r_row <= w_last_pixel ? '0 : r_row + 1'b1;
            end
            r_addr <= w_last_pixel ? '0 : r_addr + 1'b1;
        end
    end

    assign o_col        = r_col;
    assign o_row        = r_row;
    assign o_addr       = r_addr;
    assign o_last_col   = w_last_col;
    assign o_last_pixel = w_last_pixel;

endmodule
`default_nettype wire

// File: rtl/pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_streamer
//  Brief    : Reads one frame from a synchronous-read RAM and streams it as
//             8-bit pixels with enable, followed by zero flush tokens.
//  Revision : 1.0
// ============================================================================
module pixel_streamer
    import pixel_streamer_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int HEIGHT       = DEFAULT_HEIGHT,
    parameter int ADDR_W       = 17,
    parameter int FLUSH_CYCLES = FILTER_DRAIN_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pix_out,
    output logic              pix_en,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              done
);

    localparam int               COL_W           = min1_clog2(WIDTH);
    localparam int               ROW_W           = min1_clog2(HEIGHT);
    localparam int               FLUSH_W         = min1_clog2(FLUSH_CYCLES + 1);
    localparam bit               c_has_flush     = (FLUSH_CYCLES > 0);
    localparam int               c_flush_last_i  = c_has_flush ? FLUSH_CYCLES - 1 : 0;
    localparam logic [FLUSH_W-1:0] c_flush_last  = c_flush_last_i[FLUSH_W-1:0];

    state_t             r_state;
    state_t             w_next_state;

    logic               w_issue_pix;
    logic               w_issue_flush;
    logic               w_frame_clear;
    logic               w_flush_last;
    logic               w_frame_last;

    logic [COL_W-1:0]   w_col;
    logic [ROW_W-1:0]   w_row;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_last_col;
    logic               w_last_pixel;

    logic [FLUSH_W-1:0] r_flush_cnt;
    logic [ADDR_W-1:0]  r_last_addr;

    logic               r_tok_valid;
    logic               r_tok_flush;
    logic               r_tok_sof;
    logic               r_tok_eol;
    logic               r_tok_last;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_frame_clear),
        .i_advance    (w_issue_pix),
        .o_col        (w_col),
        .o_row        (w_row),
        .o_addr       (w_addr),
        .o_last_col   (w_last_col),
        .o_last_pixel (w_last_pixel)
    );

    assign w_flush_last = (r_flush_cnt == c_flush_last);
    assign w_frame_last = (w_issue_pix && w_last_pixel && !c_has_flush)
                       || (w_issue_flush && w_flush_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!hold && w_last_pixel) begin
                    w_next_state = c_has_flush ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!hold && w_flush_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_issue_pix   = 1'b0;
        w_issue_flush = 1'b0;
        w_frame_clear = 1'b0;
        busy          = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE:   w_frame_clear = start;
            ST_STREAM: w_issue_pix   = !hold;
            ST_FLUSH:  w_issue_flush = !hold;
            default:   ;
        endcase
        mem_rd   = w_issue_pix;
        mem_addr = w_issue_pix ? w_addr : r_last_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt <= '0;
            r_last_addr <= '0;
        end else begin
            if (w_issue_flush) begin
                r_flush_cnt <= w_flush_last ? '0 : r_flush_cnt + 1'b1;
            end
            if (w_issue_pix) begin
                r_last_addr <= w_addr;
            end
        end
    end

    // Token side-band travels one cycle behind the issue, aligned with the
    // RAM read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tok_valid <= 1'b0;
            r_tok_flush <= 1'b0;
            r_tok_sof   <= 1'b0;
            r_tok_eol   <= 1'b0;
            r_tok_last  <= 1'b0;
        end else begin
            r_tok_valid <= w_issue_pix || w_issue_flush;
            r_tok_flush <= w_issue_flush;
            r_tok_sof   <= w_issue_pix && (w_col == '0) && (w_row == '0);
            r_tok_eol   <= w_issue_pix && w_last_col;
            r_tok_last  <= w_frame_last;
        end
    end

    assign pix_en  = r_tok_valid;
    assign pix_out = (r_tok_valid && !r_tok_flush) ? mem_rdata : 8'd0;
    assign sof     = r_tok_sof;
    assign eol     = r_tok_eol;
    assign done    = r_tok_last;

endmodule
`default_nettype wire

// File: tb/tb_pixel_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_streamer
//  Brief    : Self-checking bench for pixel_streamer, with and without flush.
//  Revision : 1.0
// ============================================================================
module tb_pixel_streamer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int N  = W * H;
    localparam int F0 = 5;
    localparam int F1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          hold;
    logic [AW-1:0] mem_addr  [2];
    logic          mem_rd    [2];
    logic [7:0]    mem_rdata [2];
    logic [7:0]    pix_out   [2];
    logic          pix_en    [2];
    logic          sof       [2];
    logic          eol       [2];
    logic          busy      [2];
    logic          done      [2];

    logic [7:0] ram [0:(1<<AW)-1];

    pixel_streamer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FLUSH_CYCLES(F0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .mem_rdata(mem_rdata[0]),
        .pix_out(pix_out[0]), .pix_en(pix_en[0]), .sof(sof[0]), .eol(eol[0]),
        .busy(busy[0]), .done(done[0])
    );

    pixel_streamer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FLUSH_CYCLES(F1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .mem_rdata(mem_rdata[1]),
        .pix_out(pix_out[1]), .pix_en(pix_en[1]), .sof(sof[1]), .eol(eol[1]),
        .busy(busy[1]), .done(done[1])
    );

    always @(posedge clk) if (mem_rd[0]) mem_rdata[0] <= ram[mem_addr[0]];
    always @(posedge clk) if (mem_rd[1]) mem_rdata[1] <= ram[mem_addr[1]];

    // Reference: a frame is just a token index 0..N+F-1 issued on every
    // non-held busy cycle and delivered one cycle later.
    int m_f        [2] = '{F0, F1};
    bit m_active   [2];
    int m_issued   [2];
    bit m_prev     [2];
    int m_prev_idx [2];
    int m_tok_cnt  [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_en, last_en, en_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_cycle(input int k);
        logic       iss, rd, exp_done;
        logic [5:0] got_ctl, exp_ctl;
        logic [7:0] exp_pix;
        int         idx;
        iss      = m_active[k] && !hold;
        rd       = iss && (m_issued[k] < N);
        idx      = m_prev_idx[k];
        exp_done = m_prev[k] && (idx == N + m_f[k] - 1);
        if (pix_en[k]) m_tok_cnt[k]++;
        got_ctl = {busy[k], mem_rd[k], pix_en[k], sof[k], eol[k], done[k]};
        exp_ctl = {m_active[k], rd, m_prev[k], m_prev[k] && idx == 0,
                   m_prev[k] && idx < N && (idx % W) == W - 1, exp_done};
        check($sformatf("ctl%0d{busy,rd,en,sof,eol,done}", k), 32'(got_ctl), 32'(exp_ctl));
        if (rd) check($sformatf("addr%0d", k), 32'(mem_addr[k]), 32'(m_issued[k]));
        if (m_prev[k]) begin
            exp_pix = (idx < N) ? ram[idx] : 8'd0;
            check($sformatf("pix%0d", k), 32'(pix_out[k]), 32'(exp_pix));
        end
        if (exp_done) check($sformatf("frame_tokens%0d", k), 32'(m_tok_cnt[k]), 32'(N + m_f[k]));
    endtask

    task automatic model_advance(input int k);
        logic iss;
        if (reset) begin
            m_active[k] = 1'b0;
            m_issued[k] = 0;
            m_prev[k]   = 1'b0;
        end else if (m_active[k]) begin
            iss = !hold;
            m_prev[k]     = iss;
            m_prev_idx[k] = m_issued[k];
            if (iss) begin
                m_issued[k]++;
                if (m_issued[k] == N + m_f[k]) m_active[k] = 1'b0;
            end
        end else begin
            m_prev[k] = 1'b0;
            if (start) begin
                m_active[k]  = 1'b1;
                m_issued[k]  = 0;
                m_tok_cnt[k] = 0;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_cycle(k);
        if (pix_en[0]) begin
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
        end
        for (int k = 0; k < 2; k++) model_advance(k);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wait(input int maxc);
        int c = 0;
        while ((m_active[0] || m_active[1] || m_prev[0] || m_prev[1]) && c < maxc) begin
            cycle();
            c++;
        end
        check("idle_within_budget", 32'(c < maxc), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'(i + 1);
        reset = 1'b1; start = 1'b0; hold = 1'b0;
        first_en = -1; last_en = 0; en_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ctl%0d", k),
                  32'({busy[k], mem_rd[k], pix_en[k], sof[k], eol[k], done[k]}), 32'd0);
            check($sformatf("rst_pix%0d", k), 32'(pix_out[k]), 32'd0);
            check($sformatf("rst_addr%0d", k), 32'(mem_addr[k]), 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0; m_issued[k] = 0; m_prev[k] = 1'b0;
            m_prev_idx[k] = 0; m_tok_cnt[k] = 0;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

        // Basic frame
        start = 1'b1; cycle(); start = 1'b0;
        idle_wait(100);
        repeat (2) cycle();

        // Hold gaps: three in row 1, two during flush
        first_en = -1; en_cnt = 0;
        start = 1'b1; cycle(); start = 1'b0;
        repeat (5) cycle();
        hold = 1'b1; repeat (3) cycle();
        hold = 1'b0; repeat (10) cycle();
        hold = 1'b1; repeat (2) cycle();
        hold = 1'b0;
        idle_wait(100);
        check("hold_span", 32'(last_en - first_en), 32'(N + F0 - 1 + 5));
        check("hold_tokens", 32'(en_cnt), 32'(N + F0));
        repeat (2) cycle();

        // Start while busy, at the IDLE-return cycle, and right after done
        start = 1'b1; cycle(); start = 1'b0;
        repeat (4) cycle();
        start = 1'b1; cycle(); start = 1'b0;
        for (int c = 0; c < 100 && !(m_active[0] && m_issued[0] == N + F0 - 1); c++) cycle();
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        idle_wait(100);
        repeat (2) cycle();

        // Reset at the sixth pixel, then a fresh frame
        start = 1'b1; cycle(); start = 1'b0;
        for (int c = 0; c < 100 && !(m_prev[0] && m_prev_idx[0] == 5); c++) cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        idle_wait(100);

        // Randomized start/hold with occasional reset
        for (int i = 0; i < 600; i++) begin
            hold  = ($urandom_range(0, 99) < 30);
            start = ($urandom_range(0, 99) < 15);
            reset = ($urandom_range(0, 99) < 2);
            cycle();
        end
        reset = 1'b0; start = 1'b0; hold = 1'b0;
        idle_wait(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
